// File: rtl/sop_eval_pipe.sv
// Programmable sum-of-products evaluator with a two-stage valid/ready pipeline.
// F = (OR of matching enable terms) AND NOT (OR of matching inhibit terms).
module sop_eval_pipe #(
  parameter int unsigned N_IN    = 5,
  parameter int unsigned N_TERMS = 4,
  localparam int unsigned IDX_W  = $clog2(N_TERMS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_idx,
  input  logic [N_IN-1:0]    cfg_care,
  input  logic [N_IN-1:0]    cfg_pol,
  input  logic               cfg_inh,
  input  logic               cfg_en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN-1:0]    in_vec,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_f,
  output logic [N_TERMS-1:0] out_terms
);

  // Term configuration
  logic [N_TERMS-1:0][N_IN-1:0] care_q, care_d;
  logic [N_TERMS-1:0][N_IN-1:0] pol_q, pol_d;
  logic [N_TERMS-1:0]           inh_q, inh_d;
  logic [N_TERMS-1:0]           en_q, en_d;

  // Pipeline stages
  logic               s1_valid_q, s1_valid_d;
  logic               s1_f_q, s1_f_d;
  logic [N_TERMS-1:0] s1_m_q, s1_m_d;
  logic               s2_valid_q, s2_valid_d;
  logic               s2_f_q, s2_f_d;
  logic [N_TERMS-1:0] s2_m_q, s2_m_d;

  logic [N_TERMS-1:0] m_c;
  logic               f_c;
  logic               s2_load_c;
  logic               accept_c;

  assign s2_load_c = ~s2_valid_q | out_ready;
  assign in_ready  = ~s1_valid_q | s2_load_c;
  assign accept_c  = in_valid & in_ready;

  assign out_valid = s2_valid_q;
  assign out_f     = s2_f_q;
  assign out_terms = s2_m_q;

  // Term matches and decision from the config as registered before this edge
  always_comb begin
    m_c = '0;
    for (int j = 0; j < N_TERMS; j++) begin
      m_c[j] = en_q[j] & (&(~care_q[j] | ~(in_vec ^ pol_q[j])));
    end
    f_c = (|(m_c & ~inh_q)) & ~(|(m_c & inh_q));
  end

  // Config write; an out-of-range index matches no term and is dropped
  always_comb begin
    care_d = care_q;
    pol_d  = pol_q;
    inh_d  = inh_q;
    en_d   = en_q;
    for (int j = 0; j < N_TERMS; j++) begin
      if (cfg_we && (cfg_idx == IDX_W'(j))) begin
        care_d[j] = cfg_care;
        pol_d[j]  = cfg_pol;
        inh_d[j]  = cfg_inh;
        en_d[j]   = cfg_en;
      end
    end
  end

  // Pipeline next state: stage 2 loads when empty or draining, stage 1 refills in the same cycle
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_f_d     = s1_f_q;
    s1_m_d     = s1_m_q;
    s2_valid_d = s2_valid_q;
    s2_f_d     = s2_f_q;
    s2_m_d     = s2_m_q;
    if (s2_load_c) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_f_d = s1_f_q;
        s2_m_d = s1_m_q;
      end
    end
    if (accept_c) begin
      s1_valid_d = 1'b1;
      s1_f_d     = f_c;
      s1_m_d     = m_c;
    end else if (s2_load_c) begin
      s1_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      care_q     <= '0;
      pol_q      <= '0;
      inh_q      <= '0;
      en_q       <= '0;
      s1_valid_q <= 1'b0;
      s1_f_q     <= 1'b0;
      s1_m_q     <= '0;
      s2_valid_q <= 1'b0;
      s2_f_q     <= 1'b0;
      s2_m_q     <= '0;
    end else begin
      care_q     <= care_d;
      pol_q      <= pol_d;
      inh_q      <= inh_d;
      en_q       <= en_d;
      s1_valid_q <= s1_valid_d;
      s1_f_q     <= s1_f_d;
      s1_m_q     <= s1_m_d;
      s2_valid_q <= s2_valid_d;
      s2_f_q     <= s2_f_d;
      s2_m_q     <= s2_m_d;
    end
  end

endmodule

// File: tb/tb_sop_eval_pipe.sv
// Bench for sop_eval_pipe: one 4-term and one 3-term instance share stimulus,
// each checked against a scoreboard of results computed from the term rules.
module tb_sop_eval_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_idx;
  logic [4:0] cfg_care, cfg_pol;
  logic       cfg_inh, cfg_en;
  logic       in_valid, out_ready;
  logic [4:0] in_vec;

  logic       in_ready_a, out_valid_a, out_f_a;
  logic [3:0] out_terms_a;
  logic       in_ready_b, out_valid_b, out_f_b;
  logic [2:0] out_terms_b;

  always #5 clk = ~clk;

  sop_eval_pipe #(.N_IN(5), .N_TERMS(4)) u_dut_a (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_care(cfg_care), .cfg_pol(cfg_pol), .cfg_inh(cfg_inh), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_vec(in_vec),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_f(out_f_a),
    .out_terms(out_terms_a)
  );

  sop_eval_pipe #(.N_IN(5), .N_TERMS(3)) u_dut_b (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
    .cfg_care(cfg_care), .cfg_pol(cfg_pol), .cfg_inh(cfg_inh), .cfg_en(cfg_en),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_vec(in_vec),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_f(out_f_b),
    .out_terms(out_terms_b)
  );

  // Reference config: index 0 models the 4-term instance, index 1 the 3-term one
  logic [4:0] mcare [2][4];
  logic [4:0] mpol  [2][4];
  logic       minh  [2][4];
  logic       men   [2][4];

  typedef struct {
    logic       f;
    logic [3:0] t;
  } res_t;

  res_t qa[$];
  res_t qb[$];
  int   ageq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model_eval(input int d, input int nt, input logic [4:0] v);
    res_t r;
    logic hit, any_en, any_inh;
    r.t = '0;
    any_en = 1'b0;
    any_inh = 1'b0;
    for (int j = 0; j < nt; j++) begin
      hit = men[d][j];
      for (int i = 0; i < 5; i++)
        if (mcare[d][j][i] && (v[i] != mpol[d][j][i])) hit = 1'b0;
      r.t[j] = hit;
      if (hit && minh[d][j])  any_inh = 1'b1;
      if (hit && !minh[d][j]) any_en  = 1'b1;
    end
    r.f = any_en && !any_inh;
    return r;
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int j = 0; j < 4; j++) begin
        mcare[d][j] = '0; mpol[d][j] = '0; minh[d][j] = 1'b0; men[d][j] = 1'b0;
      end
    qa.delete(); qb.delete(); ageq.delete();
  endtask

  // Called just after a falling edge with inputs set; checks, updates model, advances one clock
  task automatic cycle();
    logic rdy_exp, vld_exp, acc;
    res_t ea, eb;
    #1;
    rdy_exp = (ageq.size() < 2) || out_ready;
    vld_exp = (ageq.size() > 0) && (ageq[0] >= 2);
    if (!rst) begin
      check("in_ready_a", 32'(in_ready_a), 32'(rdy_exp));
      check("in_ready_b", 32'(in_ready_b), 32'(rdy_exp));
      check("out_valid_a", 32'(out_valid_a), 32'(vld_exp));
      check("out_valid_b", 32'(out_valid_b), 32'(vld_exp));
      if (vld_exp) begin
        ea = qa[0];
        eb = qb[0];
        check("out_f_a", 32'(out_f_a), 32'(ea.f));
        check("out_terms_a", 32'(out_terms_a), 32'(ea.t));
        check("out_f_b", 32'(out_f_b), 32'(eb.f));
        check("out_terms_b", 32'(out_terms_b), 32'(eb.t[2:0]));
      end
    end
    if (rst) begin
      model_clear();
    end else begin
      acc = in_valid && rdy_exp;
      if (vld_exp && out_ready) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
        void'(ageq.pop_front());
      end
      foreach (ageq[i]) ageq[i] = ageq[i] + 1;
      if (acc) begin
        qa.push_back(model_eval(0, 4, in_vec));
        qb.push_back(model_eval(1, 3, in_vec));
        ageq.push_back(1);
      end
      if (cfg_we) begin
        for (int d = 0; d < 2; d++) begin
          if (int'(cfg_idx) < ((d == 0) ? 4 : 3)) begin
            mcare[d][cfg_idx] = cfg_care;
            mpol[d][cfg_idx]  = cfg_pol;
            minh[d][cfg_idx]  = cfg_inh;
            men[d][cfg_idx]   = cfg_en;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic drive(input logic iv, input logic [4:0] v, input logic ordy);
    in_valid = iv; in_vec = v; out_ready = ordy;
    cycle();
  endtask

  task automatic wcfg(input logic [1:0] idx, input logic [4:0] care, input logic [4:0] pol,
                      input logic inh, input logic en, input logic iv, input logic [4:0] v);
    cfg_we = 1'b1; cfg_idx = idx; cfg_care = care; cfg_pol = pol; cfg_inh = inh; cfg_en = en;
    drive(iv, v, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 5'd0, 1'b1);
    rst = 1'b0;
    #1;
    check("rst_out_valid_a", 32'(out_valid_a), 32'd0);
    check("rst_out_f_a", 32'(out_f_a), 32'd0);
    check("rst_out_terms_a", 32'(out_terms_a), 32'd0);
    check("rst_out_valid_b", 32'(out_valid_b), 32'd0);
    check("rst_out_terms_b", 32'(out_terms_b), 32'd0);
    check("rst_in_ready_a", 32'(in_ready_a), 32'd1);
  endtask

  task automatic program_legacy();
    wcfg(2'd0, 5'b00011, 5'b00011, 1'b0, 1'b1, 1'b0, 5'd0);
    wcfg(2'd1, 5'b11100, 5'b11000, 1'b1, 1'b1, 1'b0, 5'd0);
  endtask

  task automatic drain();
    for (int k = 0; k < 3; k++) drive(1'b0, 5'd0, 1'b1);
  endtask

  logic [4:0] legacy_vecs [5];

  initial begin
    legacy_vecs[0] = 5'b00011; legacy_vecs[1] = 5'b11011; legacy_vecs[2] = 5'b11111;
    legacy_vecs[3] = 5'b01011; legacy_vecs[4] = 5'b00001;
    rst = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_care = '0; cfg_pol = '0;
    cfg_inh = 1'b0; cfg_en = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
    model_clear();
    @(negedge clk);
    do_reset();

    // Legacy function streamed back to back
    program_legacy();
    for (int k = 0; k < 5; k++) drive(1'b1, legacy_vecs[k], 1'b1);
    drain();

    // Reset clears the config: everything disabled
    do_reset();
    drive(1'b1, 5'b10101, 1'b1);
    drain();

    // Backpressure for 4 cycles with a continuously valid source
    program_legacy();
    for (int k = 0; k < 4; k++) drive(1'b1, 5'($urandom), 1'b0);
    for (int k = 0; k < 4; k++) drive(1'b1, 5'($urandom), 1'b1);
    drain();

    // Config write in the same cycle as an accept uses the old config
    wcfg(2'd1, 5'b11100, 5'b11000, 1'b1, 1'b0, 1'b1, 5'b11011);
    drive(1'b1, 5'b11011, 1'b1);
    drain();

    // Index 3 is a real term for the 4-term instance, out of range for the 3-term one
    wcfg(2'd3, 5'b00000, 5'b00000, 1'b0, 1'b1, 1'b0, 5'd0);
    for (int k = 0; k < 6; k++) drive(1'b1, 5'($urandom), 1'b1);
    drain();

    // Reset with both stages full discards in-flight vectors
    program_legacy();
    for (int k = 0; k < 3; k++) drive(1'b1, 5'b00011, 1'b0);
    do_reset();
    drive(1'b1, 5'b00011, 1'b1);
    drain();

    // Randomized traffic with interleaved config writes and occasional resets
    for (int k = 0; k < 500; k++) begin
      if (($urandom % 150) == 0) begin
        do_reset();
      end else begin
        if (($urandom % 6) == 0) begin
          cfg_we   = 1'b1;
          cfg_idx  = 2'($urandom);
          cfg_care = 5'($urandom);
          cfg_pol  = 5'($urandom);
          cfg_inh  = 1'($urandom);
          cfg_en   = (($urandom % 4) != 0);
        end
        drive((($urandom % 4) != 0), 5'($urandom), (($urandom % 4) != 0));
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
